// File: rtl/xsim_indication_framer.sv
// Store-and-forward framer: buffers whole portal indication messages,
// then emits a frame-header beat followed by the message words.
module xsim_indication_framer #(
    parameter int DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] portal,
    input  logic [31:0] in_first,
    input  logic        RDY_in_first,
    input  logic        RDY_in_deq,
    output logic        EN_in_deq,
    output logic [31:0] beat,
    output logic        en_beat,
    input  logic        RDY_beat,
    output logic        err_len
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {I_HDR, I_BODY} in_st_e;
    typedef enum logic [1:0] {O_IDLE, O_FRAME, O_DATA} out_st_e;

    in_st_e        ist_q, ist_d;
    out_st_e       ost_q, ost_d;
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] msg_q, msg_d;
    logic [15:0]   remain_q, remain_d;
    logic [15:0]   out_remain_q, out_remain_d;
    logic          err_q, err_d;
    logic          push, pop, msg_inc, msg_dec;
    logic [15:0]   hdr_len;
    logic          len_ok;
    logic [31:0]   head;
    logic          unused_portal;

    assign unused_portal = ^portal[31:16];
    assign head          = mem_q[rd_ptr_q];
    assign hdr_len       = in_first[15:0];
    assign len_ok        = (hdr_len != 16'd0) && (hdr_len <= 16'(DEPTH));
    assign err_len       = err_q;

    always_comb begin
        ist_d     = ist_q;
        remain_d  = remain_q;
        err_d     = err_q;
        push      = 1'b0;
        msg_inc   = 1'b0;
        EN_in_deq = !RST && RDY_in_first && RDY_in_deq
                    && (cnt_q < CW'(DEPTH));
        if (EN_in_deq) begin
            unique case (ist_q)
                I_HDR: begin
                    if (len_ok) begin
                        push     = 1'b1;
                        remain_d = hdr_len - 16'd1;
                        if (hdr_len == 16'd1) msg_inc = 1'b1;
                        else ist_d = I_BODY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                I_BODY: begin
                    push     = 1'b1;
                    remain_d = remain_q - 16'd1;
                    if (remain_q == 16'd1) begin
                        msg_inc = 1'b1;
                        ist_d   = I_HDR;
                    end
                end
                default: ist_d = I_HDR;
            endcase
        end
        if (RST) begin
            ist_d    = I_HDR;
            remain_d = 16'd0;
            err_d    = 1'b0;
        end
    end

    // Next-state looks at the message count after this cycle's update,
    // so a message completing now is framed on the very next cycle.
    always_comb begin
        ost_d        = ost_q;
        out_remain_d = out_remain_q;
        pop          = 1'b0;
        msg_dec      = 1'b0;
        beat         = 32'd0;
        en_beat      = !RST && RDY_beat && (ost_q != O_IDLE);
        unique case (ost_q)
            O_IDLE: begin
                if ((msg_q != '0) || msg_inc) ost_d = O_FRAME;
            end
            O_FRAME: begin
                beat = {portal[15:0], head[15:0]};
                if (en_beat) begin
                    out_remain_d = head[15:0];
                    ost_d        = O_DATA;
                end
            end
            O_DATA: begin
                beat = head;
                if (en_beat) begin
                    pop          = 1'b1;
                    out_remain_d = out_remain_q - 16'd1;
                    if (out_remain_q == 16'd1) begin
                        msg_dec = 1'b1;
                        if ((msg_q > CW'(1)) || msg_inc) ost_d = O_FRAME;
                        else ost_d = O_IDLE;
                    end
                end
            end
            default: ost_d = O_IDLE;
        endcase
        if (RST) begin
            ost_d        = O_IDLE;
            out_remain_d = 16'd0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        msg_d    = msg_q + CW'(msg_inc) - CW'(msg_dec);
        if (RST) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            msg_d    = '0;
        end
    end

    always_ff @(posedge CLK) begin
        ist_q        <= ist_d;
        ost_q        <= ost_d;
        wr_ptr_q     <= wr_ptr_d;
        rd_ptr_q     <= rd_ptr_d;
        cnt_q        <= cnt_d;
        msg_q        <= msg_d;
        remain_q     <= remain_d;
        out_remain_q <= out_remain_d;
        err_q        <= err_d;
        if (push) mem_q[wr_ptr_q] <= in_first;
    end

endmodule

// File: tb/tb_xsim_indication_framer.sv
// Bench for xsim_indication_framer: directed scenarios plus a randomized
// run checked against a message-level model of expected beats.
module tb_xsim_indication_framer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        RST;
    logic [31:0] portal;
    logic [31:0] in_first;
    logic        RDY_in_first;
    logic        RDY_in_deq;
    logic        EN_in_deq;
    logic [31:0] beat;
    logic        en_beat;
    logic        RDY_beat;
    logic        err_len;

    xsim_indication_framer #(.DEPTH(DEPTH)) dut (
        .CLK(clk), .RST(RST), .portal(portal),
        .in_first(in_first), .RDY_in_first(RDY_in_first),
        .RDY_in_deq(RDY_in_deq), .EN_in_deq(EN_in_deq),
        .beat(beat), .en_beat(en_beat), .RDY_beat(RDY_beat),
        .err_len(err_len)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ncyc = 0, nbeats = 0, ndeq = 0;
    int first_beat = -1, last_beat = -1, last_deq = -1, first_deq = -1;
    int rmode = 1;
    bit in_rand = 0, tog = 0, hold_valid = 0;
    logic [31:0] hold_val;
    logic exp_err = 0;
    logic [31:0] src_q[$];
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        RDY_in_first = (src_q.size() != 0)
                       && (!in_rand || $urandom_range(3) != 0);
        in_first = (src_q.size() != 0) ? src_q[0] : 32'($urandom);
        RDY_in_deq = !in_rand || $urandom_range(3) != 0;
        case (rmode)
            0: RDY_beat = 1'b0;
            1: RDY_beat = 1'b1;
            2: RDY_beat = tog;
            default: RDY_beat = 1'($urandom_range(1));
        endcase
    endtask

    task automatic clr();
        nbeats = 0; ndeq = 0;
        first_beat = -1; last_beat = -1; last_deq = -1; first_deq = -1;
    endtask

    task automatic cyc();
        logic [31:0] e;
        @(negedge clk);
        ncyc++;
        if (en_beat) begin
            chk("beat_pending", {31'd0, en_beat},
                {31'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("beat", beat, e);
            end
            if (hold_valid) chk("beat_hold", beat, hold_val);
            hold_valid = 0;
            if (first_beat < 0) first_beat = ncyc;
            last_beat = ncyc;
            nbeats++;
        end else if (!RST && !RDY_beat && beat != 32'd0) begin
            if (hold_valid) chk("beat_hold", beat, hold_val);
            hold_valid = 1;
            hold_val = beat;
        end
        if (EN_in_deq) begin
            void'(src_q.pop_front());
            if (first_deq < 0) first_deq = ncyc;
            last_deq = ncyc;
            ndeq++;
        end
        @(posedge clk);
        #1;
        tog = ~tog;
        drive();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            cyc();
            n++;
        end
        chk("drain", 32'(src_q.size() + exp_q.size()), 32'd0);
    endtask

    task automatic push_msg(input logic [15:0] meth, input int len);
        logic [31:0] hdr, w;
        hdr = {meth, 16'(len)};
        src_q.push_back(hdr);
        exp_q.push_back({portal[15:0], 16'(len)});
        exp_q.push_back(hdr);
        for (int i = 1; i < len; i++) begin
            w = $urandom;
            src_q.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    initial begin
        logic [31:0] w1, w2, w3;
        int n, exp_beats, l;
        RST = 1'b1;
        portal = 32'h0000_0002;
        drive();
        repeat (3) cyc();
        RST = 1'b0;
        drive();
        #1;
        chk("rst_en_beat", {31'd0, en_beat}, 32'd0);
        chk("rst_beat", beat, 32'd0);
        chk("rst_err", {31'd0, err_len}, 32'd0);
        chk("rst_en_deq", {31'd0, EN_in_deq}, 32'd0);

        // single message
        clr();
        src_q = {32'h0005_0003, 32'h0000_000A, 32'h0000_000B};
        exp_q = {32'h0002_0003, 32'h0005_0003, 32'h0000_000A,
                 32'h0000_000B};
        drive();
        drain(100);
        chk("single_latency", 32'(first_beat), 32'(last_deq + 1));
        chk("single_nbeats", 32'(nbeats), 32'd4);
        chk("single_span", 32'(last_beat - first_beat), 32'd3);

        // store-and-forward
        clr();
        w1 = $urandom; w2 = $urandom; w3 = $urandom;
        src_q = {32'h0001_0004, w1, w2};
        exp_q = {32'h0002_0004, 32'h0001_0004, w1, w2, w3};
        drive();
        n = 0;
        while (src_q.size() != 0 && n < 50) begin cyc(); n++; end
        repeat (10) cyc();
        chk("sf_no_beat", 32'(nbeats), 32'd0);
        src_q.push_back(w3);
        drive();
        drain(100);
        chk("sf_latency", 32'(first_beat), 32'(last_deq + 1));
        chk("sf_nbeats", 32'(nbeats), 32'd5);

        // backpressure with toggling RDY_beat
        clr();
        rmode = 2;
        w1 = $urandom; w2 = $urandom;
        src_q = {32'h0011_0002, w1, 32'h0012_0002, w2};
        exp_q = {32'h0002_0002, 32'h0011_0002, w1,
                 32'h0002_0002, 32'h0012_0002, w2};
        drive();
        drain(100);
        chk("bp_nbeats", 32'(nbeats), 32'd6);
        rmode = 1;
        drive();
        repeat (4) cyc();
        chk("bp_idle_nbeats", 32'(nbeats), 32'd6);
        chk("bp_idle_beat", beat, 32'd0);

        // full FIFO
        clr();
        rmode = 0;
        hold_valid = 0;
        push_msg(16'h0003, DEPTH);
        push_msg(16'h0004, 1);
        drive();
        repeat (25) cyc();
        chk("full_ndeq", 32'(ndeq), 32'(DEPTH));
        #1;
        chk("full_en_deq", {31'd0, EN_in_deq}, 32'd0);
        clr();
        rmode = 1;
        drive();
        drain(100);
        chk("full_resume", 32'(first_deq), 32'(first_beat + 2));
        chk("full_nbeats", 32'(nbeats), 32'(DEPTH + 3));

        // illegal lengths
        clr();
        src_q = {32'h0000_0000, 32'h0000_0011, 32'h0007_0001};
        exp_q = {32'h0002_0001, 32'h0007_0001};
        exp_err = 1'b1;
        drive();
        drain(100);
        chk("ill_err", {31'd0, err_len}, {31'd0, exp_err});
        chk("ill_nbeats", 32'(nbeats), 32'd2);
        repeat (3) cyc();
        chk("ill_err_sticky", {31'd0, err_len}, 32'd1);

        // reset during O_DATA
        clr();
        w1 = $urandom; w2 = $urandom;
        src_q = {32'h0009_0003, w1, w2};
        exp_q = {32'h0002_0003, 32'h0009_0003, w1, w2};
        drive();
        n = 0;
        while (nbeats == 0 && n < 50) begin cyc(); n++; end
        chk("mid_frame_seen", 32'(nbeats), 32'd1);
        RST = 1'b1;
        drive();
        cyc();
        RST = 1'b0;
        exp_q.delete();
        hold_valid = 0;
        exp_err = 1'b0;
        drive();
        #1;
        chk("mid_en_beat", {31'd0, en_beat}, 32'd0);
        chk("mid_beat", beat, 32'd0);
        chk("mid_err", {31'd0, err_len}, 32'd0);
        clr();
        w1 = $urandom;
        src_q = {32'h000A_0002, w1};
        exp_q = {32'h0002_0002, 32'h000A_0002, w1};
        drive();
        drain(100);
        chk("mid_after_nbeats", 32'(nbeats), 32'd3);
        repeat (3) cyc();
        chk("mid_after_idle", 32'(nbeats), 32'd3);

        // randomized traffic against the message model
        clr();
        in_rand = 1;
        rmode = 3;
        exp_beats = 0;
        for (int m = 0; m < 40; m++) begin
            if ($urandom_range(7) == 0) begin
                l = ($urandom_range(1) == 0) ? 0
                    : int'($urandom_range(65535, DEPTH + 1));
                src_q.push_back({16'($urandom), 16'(l)});
                exp_err = 1'b1;
            end
            l = $urandom_range(DEPTH, 1);
            push_msg(16'($urandom), l);
            exp_beats += l + 1;
        end
        drive();
        drain(6000);
        chk("rand_nbeats", 32'(nbeats), 32'(exp_beats));
        chk("rand_err", {31'd0, err_len}, {31'd0, exp_err});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xsim_indication_framer.md
# xsim_indication_framer

Store-and-forward framer between a portal's indication message pipe and the XSim beat source. It pulls 32-bit indication words from the portal's `first`/`deq` interface and buffers each message until it is complete. It then emits the message to the simulator transport as a frame-header beat followed by the message words. A message is never presented to the transport partially, so host-side reads never stall mid-message.

## Interface
- `DEPTH`, default 16: word FIFO depth; power of two, ≥2; also the maximum legal message length in words.
- `CLK` input 1: sole clock; all state updates on rising edge.
- `RST` input 1: synchronous, active-high reset.
- `portal` input 32: portal id. Only [15:0] is used, and it must be stable while `RST` is low.
- `in_first` input 32: head word of the indication pipe.
- `RDY_in_first` input 1: `in_first` is valid.
- `RDY_in_deq` input 1: the pipe can dequeue.
- `EN_in_deq` output 1: dequeue the head word this cycle.
- `beat` output 32: outgoing transport beat.
- `en_beat` output 1: `beat` is transferred this cycle.
- `RDY_beat` input 1: transport can accept a beat.
- `err_len` output 1: sticky flag for an illegal message length.

## Operation
- **Message format:** word 0 is the header. Header [31:16] is the method id and header [15:0] is `len`, the total word count including the header. Legal `len` is 1..DEPTH.
- **Input FSM**
  - States: `I_HDR` (reset), `I_BODY`.
  - `EN_in_deq = RDY_in_first && RDY_in_deq && (fifo_count < DEPTH)`.
  - `I_HDR`, dequeued word with legal `len`:
    - The word is written to the FIFO and `remain = len-1` is loaded.
    - If `len==1`, the message is complete and the state stays `I_HDR`; otherwise go to `I_BODY`.
  - `I_HDR`, dequeued word with `len==0` or `len>DEPTH`:
    - The word is dequeued and discarded, not written.
    - `err_len` is set; the state stays `I_HDR`.
  - `I_BODY`: each dequeued word is written and `remain` decrements. When `remain` reaches 0, the message is complete and the state returns to `I_HDR`.
  - On message complete, `msg_count` increments.
- **Output FSM**
  - States: `O_IDLE` (reset), `O_FRAME`, `O_DATA`.
  - `O_IDLE` goes to `O_FRAME` when `msg_count > 0`.
  - `O_FRAME`:
    - `beat = {portal[15:0], fifo_head[15:0]}`.
    - On `en_beat`, load `out_remain = fifo_head[15:0]` and go to `O_DATA`. No FIFO pop occurs.
  - `O_DATA`:
    - `beat = fifo_head`.
    - Each `en_beat` pops one word and decrements `out_remain`.
    - When the last word is popped, `msg_count` decrements and the state goes to `O_FRAME` if `msg_count` (after update) > 0, else `O_IDLE`.
  - `en_beat = RDY_beat && state ∈ {O_FRAME, O_DATA}`.
  - `beat = 0` when `en_beat` would be 0 for lack of valid data, i.e. in `O_IDLE`.
- **FIFO:** register array with a combinational head read.
  - A simultaneous push and pop is legal at any count where each is individually allowed; `fifo_count` is then unchanged.
  - There is no bypass: a word pushed in cycle t is poppable at t+1 at the earliest.
- **Counters:** a simultaneous `msg_count` increment and decrement leaves it unchanged. `msg_count` never exceeds DEPTH.
- **Deadlock freedom:** `len ≤ DEPTH` guarantees that a partial message can always fit once complete messages drain.
- **Reset** (any cycle, including mid-message) has these effects:
  - Both FSMs go to their idle states and all counts clear, so any partial or buffered messages are lost.
  - `err_len = 0`.
  - Outputs in the reset cycle's following state: `EN_in_deq` follows its equation with count 0, `en_beat = 0`, `beat = 0`.
  - While `RST` is high, `EN_in_deq = 0` and `en_beat = 0`.

## Timing
- `EN_in_deq` and `en_beat` are combinational from the inputs and registered state.
- Latency: last word of a message dequeued in cycle t → frame beat has `en_beat` available in cycle t+1 at the earliest.
- Back-to-back throughput:
  - Input: 1 word/cycle.
  - Output: `len+1` beats per message with no idle cycle between messages while `msg_count > 0` and `RDY_beat` is high.
- `RDY_beat` low holds `state`, `beat` and `out_remain` unchanged.

## Test plan
- **Single message:** `portal=2`; words 0x0005_0003, 0xA, 0xB; `RDY_beat=1` → beats 0x0002_0003, 0x0005_0003, 0xA, 0xB on 4 consecutive cycles. The first beat comes the cycle after 0xB is dequeued.
- **Store-and-forward:** feed 0x0001_0004 plus two body words, then stall input for 10 cycles → `en_beat` stays 0. Feed the 4th word → frame beat on the next cycle.
- **Backpressure:** two 2-word messages queued; `RDY_beat` toggles 1,0,1,0… → 6 beats delivered in order. `beat` is stable during low cycles, and the final `msg_count` is 0.
- **Full FIFO:** DEPTH=16; one 16-word message arrives with `RDY_beat=0` → `EN_in_deq` drops after the 16th word. Raise `RDY_beat` → 17 beats out; input resumes the cycle after the first pop.
- **Illegal length:** headers 0x0000_0000 and 0x0000_0011 (DEPTH=16) → both discarded, no beats, `err_len=1` and held. A following legal 1-word message 0x0007_0001 is emitted as 0x0002_0001, 0x0007_0001.
- **Reset mid-operation:** assert `RST` one cycle during `O_DATA` of a 3-word message → next cycle `en_beat=0`, `beat=0`, `err_len=0`, FIFO empty. A subsequent message is framed correctly.
